// File: rtl/schoolbook_ds_if.sv
// schoolbook_ds_if: start/busy/done handshake with operands and product for schoolbook_ds
interface schoolbook_ds_if #(parameter int A_W = 192, parameter int B_W = 192);
  logic start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic busy;
  logic done;
  logic [A_W+B_W-1:0] c;
  modport master(output start, a, b, input busy, done, c);
  modport slave(input start, a, b, output busy, done, c);
endinterface

// File: rtl/schoolbook_ds.sv
// schoolbook_ds: digit-serial schoolbook multiplier, DIGIT bits of b per cycle, fixed latency
module schoolbook_ds #(
  parameter int A_W = 192,
  parameter int B_W = 192,
  parameter int DIGIT = 8
) (
  input logic clk,
  input logic rst,
  schoolbook_ds_if.slave bus
);
  localparam int N = (B_W + DIGIT - 1) / DIGIT;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW = N * DIGIT;
  localparam int P_W = A_W + B_W;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, next;
  logic load, last;
  logic [A_W-1:0] a_r;
  logic [PW-1:0] b_r;
  logic [P_W-1:0] acc, pp, c_r;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT-1:0] dig;
  logic [A_W+DIGIT-1:0] prod;
  logic done_r;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    last = cnt == CNT_W'(N - 1);
    load = state != RUN && bus.start;
    next = load ? RUN : state == RUN ? (last ? FIN : RUN) : IDLE;
    dig = b_r[int'(cnt)*DIGIT +: DIGIT];
    prod = {{DIGIT{1'b0}}, a_r} * {{A_W{1'b0}}, dig};
    // b is zero-padded to N digits, so the shifted partial product never exceeds P_W bits
    pp = P_W'(prod) << (int'(cnt) * DIGIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
      c_r <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= state == FIN;
      if (state == FIN) c_r <= acc;
      if (load) begin
        a_r <= bus.a;
        b_r <= PW'(bus.b);
        acc <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= acc + pp;
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = done_r;
  assign bus.c = c_r;
endmodule
